symbol_arbiter: RTL

SYMBOL_ARBITER -- requirements
Module: symbol_arbiter

---
 rtl/symbol_arbiter_pkg.sv | 28 ++
 rtl/symbol_arbiter_burst_counter.sv | 39 +++
 rtl/symbol_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/symbol_arbiter_pkg.sv
// Shared encodings for the two-requester symbol arbiter: controller states, owner ids, burst sizing.
// Types and constants only; no timing or flow-control behaviour of its own.
package symbol_arbiter_pkg;

   localparam int CNT_W         = 4;
   localparam int MAX_BURST_DEF = 8;

   typedef logic [1:0] sym_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_SERVE = 2'd2
   } state_t;

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } owner_t;

   function automatic owner_t other_owner(input owner_t o);
      owner_t r;
      if (o == OWN_A) r = OWN_B;
      else            r = OWN_A;
      return r;
   endfunction

endpackage

// File: rtl/symbol_arbiter_burst_counter.sv
// Counts symbols accepted in one ownership; cleared on CLEAR, saturates at MAX.
// Count is registered (updates on the edge after inc_i); at_limit_o decodes the current count.
module burst_counter
   import symbol_arbiter_pkg::*;
#(
   parameter int MAX = MAX_BURST_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic inc_i,
   output logic at_limit_o
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != MAX_C)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign at_limit_o = (count_q == MAX_C);

endmodule

// File: rtl/symbol_arbiter.sv
// Arbitrates two symbol streams onto one shared Moore detector; result returns one cycle after each grant.
// A requester is stalled (gnt low) while the other owns the detector, during CLEAR, or at its burst limit.
module symbol_arbiter
   import symbol_arbiter_pkg::*;
#(
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_a,
   input  logic       req_b,
   input  logic [1:0] sym_a,
   input  logic [1:0] sym_b,
   output logic       gnt_a,
   output logic       gnt_b,
   output logic       done_a,
   output logic       done_b,
   output logic [1:0] p_a,
   output logic [1:0] p_b,
   output logic       fsm_i,
   output logic       fsm_s,
   output logic       fsm_en,
   output logic       fsm_clr,
   input  logic       fsm_p1,
   input  logic       fsm_p2
);

   state_t state_q, state_d;
   owner_t owner_q, owner_d;
   owner_t last_q,  last_d;
   logic   done_a_q, done_b_q;

   logic   req_own;
   logic   req_oth;
   sym_t   sym_own;
   logic   gnt_own;
   logic   clr_cyc;
   logic   at_limit;

   assign req_own = (owner_q == OWN_A) ? req_a : req_b;
   assign req_oth = (owner_q == OWN_A) ? req_b : req_a;
   assign sym_own = (owner_q == OWN_A) ? sym_a : sym_b;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      gnt_own = 1'b0;
      clr_cyc = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_a || req_b) begin
               state_d = ST_CLEAR;
               // On a tie the requester that was not served last wins.
               if (req_a && req_b) owner_d = other_owner(last_q);
               else if (req_a)     owner_d = OWN_A;
               else                owner_d = OWN_B;
            end
         end
         ST_CLEAR: begin
            clr_cyc = 1'b1;
            state_d = ST_SERVE;
         end
         ST_SERVE: begin
            if (at_limit && req_oth) begin
               state_d = ST_CLEAR;
               owner_d = other_owner(owner_q);
               last_d  = owner_q;
            end else if (req_own) begin
               gnt_own = 1'b1;
            end else begin
               state_d = ST_IDLE;
               last_d  = owner_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         owner_q  <= OWN_A;
         last_q   <= OWN_B;
         done_a_q <= 1'b0;
         done_b_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         done_a_q <= gnt_a;
         done_b_q <= gnt_b;
      end
   end

   burst_counter #(
      .MAX (MAX_BURST)
   ) u_burst (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (clr_cyc),
      .inc_i      (gnt_own),
      .at_limit_o (at_limit)
   );

   assign gnt_a   = gnt_own && (owner_q == OWN_A);
   assign gnt_b   = gnt_own && (owner_q == OWN_B);
   assign fsm_en  = gnt_own;
   assign fsm_clr = clr_cyc;
   assign fsm_i   = gnt_own & sym_own[1];
   assign fsm_s   = gnt_own & sym_own[0];

   // The detector has already advanced past the granted symbol, so its live outputs are the result.
   assign done_a = done_a_q;
   assign done_b = done_b_q;
   assign p_a    = done_a_q ? {fsm_p1, fsm_p2} : 2'b00;
   assign p_b    = done_b_q ? {fsm_p1, fsm_p2} : 2'b00;

endmodule
